instruction_fetch: RTL and testbench

Instruction-fetch stage of the 16-bit ThinPad pipeline, directly upstream of `MemoryModule`. Owns the program counter, drives `pc` to the memory module, and consumes `Instruct`, `MemConflict` and `noStop`. Captures the fetched word into the IF/ID pipeline register. Handles memory-port conflicts by replaying the fetch, holds on memory or decode stalls, and applies branch redirects, deferring any redirect that arrives while the stage is held.

---
 rtl/instruction_fetch_pkg.sv | 19 +
 rtl/instruction_fetch_if_id_register.sv | 27 ++
 rtl/instruction_fetch.sv | 114 +++++++++++
 tb/tb_instruction_fetch.sv | 134 +++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared constants, FSM encoding and IF/ID entry layout for the fetch stage.
package instruction_fetch_pkg;

  localparam logic [15:0] NOP_INSTRUCT = 16'h0800;
  localparam logic [15:0] BOOT_PC      = 16'h0000;

  typedef enum logic [1:0] {
    IF_RUN    = 2'd0,
    IF_HOLD   = 2'd1,
    IF_REPLAY = 2'd2
  } if_state_t;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc1;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/instruction_fetch_if_id_register.sv
// IF/ID pipeline register: load a fetched word, insert a bubble, or hold.
module if_id_register
  import instruction_fetch_pkg::*;
#(
  parameter logic [15:0] NOP       = NOP_INSTRUCT,
  parameter logic [15:0] RESET_PC1 = BOOT_PC + 16'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        bubble,
  input  logic [15:0] instr,
  input  logic [15:0] pc1,
  output if_id_t      entry
);

  always_ff @(posedge clk) begin
    if (rst) begin
      entry <= '{instr: NOP, pc1: RESET_PC1, valid: 1'b0};
    end else if (load) begin
      entry <= '{instr: instr, pc1: pc1, valid: 1'b1};
    end else if (bubble) begin
      entry <= '{instr: NOP, pc1: pc1, valid: 1'b0};
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, replays on memory-port conflicts, holds on stalls
// and defers redirects that arrive while held.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [15:0] BOOT_PC = instruction_fetch_pkg::BOOT_PC,
  parameter logic [15:0] NOP     = NOP_INSTRUCT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Instruct,
  input  logic        MemConflict,
  input  logic        noStop,
  input  logic        id_stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic [15:0] pc,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc1,
  output logic        if_id_valid,
  output logic [15:0] stall_count
);

  if_state_t   state_q, state_d;
  logic        pend_v;
  logic [15:0] pend_tgt;
  logic        advance, redirect;
  logic        load, bubble, clr_pend;
  logic [15:0] pc_d, pc1_d;
  if_id_t      entry;

  assign advance  = noStop & ~id_stall;
  assign redirect = branch_taken | pend_v;

  always_comb begin
    pc_d     = pc;
    pc1_d    = pc + 16'd1;
    load     = 1'b0;
    bubble   = 1'b0;
    clr_pend = 1'b0;
    if (advance) begin
      if (branch_taken) begin
        pc_d     = branch_target;
        pc1_d    = branch_target + 16'd1;
        bubble   = 1'b1;
        clr_pend = 1'b1;
      end else if (pend_v) begin
        pc_d     = pend_tgt;
        pc1_d    = pend_tgt + 16'd1;
        bubble   = 1'b1;
        clr_pend = 1'b1;
      end else if (MemConflict) begin
        bubble   = 1'b1;
      end else begin
        pc_d     = pc + 16'd1;
        load     = 1'b1;
      end
    end
  end

  // A redirect subsumes a conflict bubble, so only an undisturbed conflict replays.
  always_comb begin
    state_d = state_q;
    if (!advance) begin
      state_d = IF_HOLD;
    end else begin
      unique case (state_q)
        IF_HOLD:   state_d = (MemConflict && !redirect) ? IF_REPLAY : IF_RUN;
        IF_REPLAY: state_d = (MemConflict && !redirect) ? IF_REPLAY : IF_RUN;
        default:   state_d = (MemConflict && !redirect) ? IF_REPLAY : IF_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IF_RUN;
      pc          <= BOOT_PC;
      pend_v      <= 1'b0;
      pend_tgt    <= BOOT_PC;
      stall_count <= 16'd0;
    end else begin
      state_q <= state_d;
      pc      <= pc_d;
      if (!advance && branch_taken) begin
        pend_v   <= 1'b1;
        pend_tgt <= branch_target;
      end else if (clr_pend) begin
        pend_v   <= 1'b0;
      end
      if ((!advance || MemConflict) && stall_count != 16'hFFFF) begin
        stall_count <= stall_count + 16'd1;
      end
    end
  end

  if_id_register #(
    .NOP      (NOP),
    .RESET_PC1(BOOT_PC + 16'd1)
  ) u_if_id (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .bubble(bubble),
    .instr (Instruct),
    .pc1   (pc1_d),
    .entry (entry)
  );

  assign if_id_instr = entry.instr;
  assign if_id_pc1   = entry.pc1;
  assign if_id_valid = entry.valid;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed test-plan sequence followed by random traffic, checked against a cycle model.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Instruct;
  logic        MemConflict, noStop, id_stall, branch_taken;
  logic [15:0] branch_target;
  logic [15:0] pc, if_id_instr, if_id_pc1, stall_count;
  logic        if_id_valid;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0] m_pc = 16'h0000, m_instr, m_pc1, m_cnt, m_ptgt;
  logic        m_valid, m_pend;
  logic [15:0] key = 16'h0000;

  instruction_fetch dut (
    .clk(clk), .rst(rst), .Instruct(Instruct), .MemConflict(MemConflict),
    .noStop(noStop), .id_stall(id_stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .pc(pc), .if_id_instr(if_id_instr),
    .if_id_pc1(if_id_pc1), .if_id_valid(if_id_valid), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] word(input logic [15:0] a);
    return (16'h4901 + a) ^ key;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one clock edge, in terms of the architectural rules.
  task automatic model(input logic r, ns, mc, ids, bt, input logic [15:0] tgt,
                       input logic [15:0] ins);
    logic adv;
    adv = ns && !ids;
    if (r) begin
      m_pc = 16'h0000; m_instr = 16'h0800; m_pc1 = 16'h0001; m_valid = 0;
      m_cnt = 0; m_pend = 0; m_ptgt = 0;
      return;
    end
    if ((!adv || mc) && m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
    if (!adv) begin
      if (bt) begin m_pend = 1; m_ptgt = tgt; end
    end else if (bt) begin
      m_pc = tgt; m_instr = 16'h0800; m_pc1 = tgt + 1; m_valid = 0; m_pend = 0;
    end else if (m_pend) begin
      m_pc = m_ptgt; m_instr = 16'h0800; m_pc1 = m_ptgt + 1; m_valid = 0; m_pend = 0;
    end else if (mc) begin
      m_instr = 16'h0800; m_pc1 = m_pc + 1; m_valid = 0;
    end else begin
      m_instr = ins; m_pc1 = m_pc + 1; m_valid = 1; m_pc = m_pc + 1;
    end
  endtask

  task automatic cyc(input logic r, ns, mc, ids, bt, input logic [15:0] tgt);
    logic [15:0] ins;
    ins = mc ? 16'h0800 : word(m_pc);
    rst = r; noStop = ns; MemConflict = mc; id_stall = ids;
    branch_taken = bt; branch_target = tgt; Instruct = ins;
    @(posedge clk);
    #1;
    model(r, ns, mc, ids, bt, tgt, ins);
    chk("pc", pc, m_pc);
    chk("if_id_instr", if_id_instr, m_instr);
    chk("if_id_pc1", if_id_pc1, m_pc1);
    chk("if_id_valid", {15'd0, if_id_valid}, {15'd0, m_valid});
    chk("stall_count", stall_count, m_cnt);
  endtask

  initial begin
    cyc(1, 1, 0, 0, 0, 0);
    chk("reset_instr", if_id_instr, 16'h0800);
    chk("reset_pc1", if_id_pc1, 16'h0001);
    // Four free fetches, then one more to reach pc=5.
    repeat (5) cyc(0, 1, 0, 0, 0, 0);
    chk("free_pc", pc, 16'h0005);
    chk("free_last_word", if_id_instr, 16'h4905);
    // Two conflicts at pc=5, then the replayed fetch.
    repeat (2) cyc(0, 1, 1, 0, 0, 0);
    chk("conflict_pc", pc, 16'h0005);
    chk("conflict_count", stall_count, 16'd2);
    cyc(0, 1, 0, 0, 0, 0);
    chk("replay_pc1", if_id_pc1, 16'h0006);
    repeat (2) cyc(0, 1, 0, 0, 0, 0);
    // Memory hold at pc=8 with a redirect arriving mid-hold.
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 16'h0040);
    cyc(0, 0, 0, 0, 0, 0);
    chk("held_pc", pc, 16'h0008);
    cyc(0, 1, 0, 0, 0, 0);
    chk("deferred_pc", pc, 16'h0040);
    cyc(0, 1, 0, 0, 0, 0);
    chk("target_word", if_id_instr, 16'h4941);
    chk("target_pc1", if_id_pc1, 16'h0041);
    // Redirect together with a conflict.
    cyc(0, 1, 1, 0, 1, 16'h0100);
    chk("br_conflict_pc", pc, 16'h0100);
    cyc(0, 1, 0, 0, 0, 0);
    chk("no_replay_pc", pc, 16'h0101);
    // Wraparound at 16'hFFFF.
    cyc(0, 1, 0, 0, 1, 16'hFFFF);
    cyc(0, 1, 0, 0, 0, 0);
    chk("wrap_pc", pc, 16'h0000);
    chk("wrap_pc1", if_id_pc1, 16'h0000);
    // Reset during a decode stall with a redirect pending.
    cyc(0, 0, 0, 1, 1, 16'h1234);
    cyc(1, 1, 0, 1, 0, 0);
    chk("rst_stall_pc", pc, 16'h0000);
    cyc(0, 1, 0, 0, 0, 0);
    chk("rst_pend_cleared", pc, 16'h0001);
    // Random traffic.
    key = 16'($urandom);
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 99) == 0,
          $urandom_range(0, 99) >= 15,
          $urandom_range(0, 99) < 20,
          $urandom_range(0, 99) < 10,
          $urandom_range(0, 99) < 15,
          16'($urandom));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
